// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   state_t    - one-hot sequencer states (4 bits)
//   RETRY_W    - width of the retry counter output
//   RETRY_MAX  - saturation value of the retry counter
//   cnt_width  - width of the shared phase counter for a given set of
//                cycle-count parameters
package pll_seq_pkg;

  // One-hot so each output decode is a single bit test on the next state.
  typedef enum logic [3:0] {
    ST_PLL_RST   = 4'b0001,
    ST_WAIT_LOCK = 4'b0010,
    ST_STABLE    = 4'b0100,
    ST_RUN       = 4'b1000
  } state_t;

  localparam int unsigned       RETRY_W   = 8;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  // The counter only ever has to reach (largest cycle count - 1), so
  // clog2 of the largest count is enough. A degenerate all-ones
  // configuration would give zero bits, so clamp to one.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// sync_ff
// Parameterized N-stage single-bit synchronizer with synchronous reset.
// Used here for the PLL lock indicator; equally usable to carry the
// system reset into the PLL output clock domain.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, loads RESET_VALUE into all stages
//   d   - asynchronous input bit
//   q   - synchronized output (last stage)
module sync_ff #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift register; chain[0] is the metastability-exposed stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VALUE}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Runs on the PLL reference clock. Pulses the PLL reset, waits for lock,
// qualifies lock for a programmable number of cycles and only then
// releases the system reset. Lock timeouts retry the PLL reset; lock loss
// or a software request re-enters the sequence.
// Ports:
//   clk            - reference clock (same net as the PLL refclk)
//   rst            - synchronous active-high reset
//   pll_locked     - PLL lock indicator, asynchronous to clk
//   soft_reset_req - single-cycle request to restart the whole sequence
//   pll_rst        - reset to the PLL (registered)
//   sys_rst        - active-high system reset (registered)
//   ready          - sequence complete and PLL locked (registered)
//   lock_lost      - sticky: lock dropped while running
//   retry_count    - saturating count of lock-timeout retries
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               soft_reset_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             locked_s;
  logic             retry_inc;
  logic             lost_set;
  logic             restart;

  sync_ff #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b0)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Next-state decode. A soft request overrides everything except rst,
  // and lock presence/absence is tested before any counter expiry.
  always_comb begin
    state_next = state;
    retry_inc  = 1'b0;
    lost_set   = 1'b0;
    if (soft_reset_req) begin
      state_next = ST_PLL_RST;
    end else begin
      unique case (state)
        ST_PLL_RST: begin
          if (cnt == PLL_RST_LAST) state_next = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = ST_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            state_next = ST_PLL_RST;
            retry_inc  = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_next = ST_WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_next = ST_WAIT_LOCK;
            lost_set   = 1'b1;
          end
        end
        default: begin
          state_next = ST_PLL_RST;
        end
      endcase
    end
  end

  // The counter restarts on every state change, including a soft request
  // that lands while already in PLL_RST. It is frozen in RUN, where
  // nothing times out, so it never wraps.
  always_comb begin
    restart = soft_reset_req || (state_next != state);
    if (restart) begin
      cnt_next = '0;
    end else if (state == ST_RUN) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // State, counter and all outputs share one register stage. Outputs are
  // decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pll_rst <= (state_next == ST_PLL_RST);
      sys_rst <= (state_next != ST_RUN);
      ready   <= (state_next == ST_RUN);
      if (soft_reset_req) begin
        lock_lost <= 1'b0;
      end else if (lost_set) begin
        lock_lost <= 1'b1;
      end
      if (retry_inc && (retry_count != RETRY_MAX)) begin
        retry_count <= retry_count + RETRY_W'(1);
      end
    end
  end

  // Structural invariants of the encoding and output decode.
  a_state_onehot : assert property (@(posedge clk) disable iff (rst) $onehot(state));
  a_ready_vs_sys : assert property (@(posedge clk) disable iff (rst) ready == !sys_rst);
  a_pll_rst_excl : assert property (@(posedge clk) disable iff (rst) !(pll_rst && ready));

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Scoreboard bench for pll_reset_sequencer. The driver applies inputs on
// the falling edge, advances a timestamp-based reference model by one
// rising edge and queues the outputs that edge should produce. A monitor
// samples the DUT just after each rising edge and compares against the
// queue head.
module tb_pll_reset_sequencer;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned PLL_RST_CYCLES = 4;
  localparam int unsigned LOCK_TIMEOUT   = 20;
  localparam int unsigned STABLE_CYCLES  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_count;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: current phase, the edge number it began on, a
  // history of sampled lock values standing in for the synchronizer.
  typedef enum {PH_PLLRST, PH_WAIT, PH_QUAL, PH_UP} phase_t;
  phase_t  ph = PH_PLLRST;
  longint  edge_no = 0;
  longint  ph_start = 0;
  int      retries = 0;
  bit      lost = 1'b0;
  bit      hist[$];

  pll_reset_sequencer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .lock_lost      (lock_lost),
    .retry_count    (retry_count)
  );

  always #5 clk = ~clk;

  task automatic enterPhase(input phase_t p);
    ph       = p;
    ph_start = edge_no;
  endtask

  // Advance the model across one rising edge with the given inputs and
  // queue the outputs the DUT must show after it.
  task automatic modelStep(input bit r, input bit lk, input bit sr);
    bit     ls;
    longint held;
    obs_t   e;
    ls = hist[0];
    edge_no++;
    held = edge_no - ph_start;
    if (r) begin
      hist.delete();
      for (int i = 0; i < int'(SYNC_STAGES); i++) hist.push_back(1'b0);
    end else begin
      void'(hist.pop_front());
      hist.push_back(lk);
    end
    if (r) begin
      enterPhase(PH_PLLRST);
      retries = 0;
      lost    = 1'b0;
    end else if (sr) begin
      enterPhase(PH_PLLRST);
      lost = 1'b0;
    end else begin
      case (ph)
        PH_PLLRST: if (held >= PLL_RST_CYCLES) enterPhase(PH_WAIT);
        PH_WAIT: begin
          if (ls) enterPhase(PH_QUAL);
          else if (held >= LOCK_TIMEOUT) begin
            enterPhase(PH_PLLRST);
            if (retries < 255) retries++;
          end
        end
        PH_QUAL: begin
          if (!ls) enterPhase(PH_WAIT);
          else if (held >= STABLE_CYCLES) enterPhase(PH_UP);
        end
        PH_UP: begin
          if (!ls) begin
            enterPhase(PH_WAIT);
            lost = 1'b1;
          end
        end
        default: enterPhase(PH_PLLRST);
      endcase
    end
    e.pll_rst     = (ph == PH_PLLRST);
    e.sys_rst     = (ph != PH_UP);
    e.ready       = (ph == PH_UP);
    e.lock_lost   = lost;
    e.retry_count = 8'(retries);
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit r, input bit lk, input bit sr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst            = r;
      pll_locked     = lk;
      soft_reset_req = sr;
      modelStep(r, lk, sr);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, actual, required, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    checkOutput({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
    checkOutput({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
    checkOutput({tag, "_retry_count"}, 32'(retry_count), 32'd0);
  endtask

  // Monitor: one scoreboard comparison per rising edge that has a queued
  // expectation.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pll_rst, sys_rst, ready, lock_lost, retry_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("[TB] FAIL cycle_outputs t=%0t actual pll_rst=%b sys_rst=%b ready=%b lock_lost=%b retry=%0d required pll_rst=%b sys_rst=%b ready=%b lock_lost=%b retry=%0d",
                   $time, a.pll_rst, a.sys_rst, a.ready, a.lock_lost, a.retry_count,
                   e.pll_rst, e.sys_rst, e.ready, e.lock_lost, e.retry_count);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g;
    bit lk_r;
    bit sr_r;
    bit r_r;
    for (int i = 0; i < int'(SYNC_STAGES); i++) hist.push_back(1'b0);

    // Clean bring-up
    $display("[TB] clean bring-up");
    applyStimulus(1, 0, 0, 3);
    checkResetValues("reset");
    applyStimulus(0, 0, 0, 10);
    applyStimulus(0, 1, 0, 20);
    checkOutput("bringup_ready", 32'(ready), 32'd1);
    checkOutput("bringup_retry", 32'(retry_count), 32'd0);

    // Timeout retries, then saturation
    $display("[TB] timeout retry");
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 60);
    applyStimulus(0, 0, 0, 300 * 24 + 10);
    checkOutput("retry_saturated", 32'(retry_count), 32'd255);

    // Glitchy lock during qualification
    $display("[TB] glitchy lock");
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 6);
    g = int'($urandom_range(3, 9));
    applyStimulus(0, 1, 0, g);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 20);

    // Loss of lock while running, then relock
    $display("[TB] loss in run");
    applyStimulus(0, 0, 0, int'($urandom_range(1, 5)));
    applyStimulus(0, 1, 0, 20);
    checkOutput("relock_lock_lost", 32'(lock_lost), 32'd1);
    checkOutput("relock_ready", 32'(ready), 32'd1);

    // Soft reset in RUN, with a lock drop, and during PLL_RST
    $display("[TB] soft reset");
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("soft_pll_rst", 32'(pll_rst), 32'd1);
    checkOutput("soft_lock_lost", 32'(lock_lost), 32'd0);
    applyStimulus(0, 1, 0, 20);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 3);
    applyStimulus(0, 1, 0, 30);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 2);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 25);

    // Reset asserted while qualifying lock
    $display("[TB] reset mid-sequence");
    applyStimulus(0, 0, 0, 4);
    applyStimulus(0, 1, 0, 5);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkResetValues("midreset");
    checkOutput("midreset_sync", 32'(dut.locked_s), 32'd0);
    applyStimulus(0, 1, 0, 20);

    // Randomized traffic
    $display("[TB] random traffic");
    lk_r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) lk_r = ~lk_r;
      sr_r = ($urandom_range(0, 149) == 0);
      r_r  = ($urandom_range(0, 399) == 0);
      applyStimulus(r_r, lk_r, sr_r, 1);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences reset across the PLL boundary. Runs on the 50 MHz reference clock and drives the PLL's `rst` input. It watches the PLL's asynchronous `locked` output and holds the 8 MHz system domain in reset until lock has been stable for a programmable time. Lock-acquisition timeouts trigger PLL reset retries, and loss of lock or a software request re-enters the reset sequence.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2).
- `PLL_RST_CYCLES`, 16: clk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: clk cycles to wait for lock before retrying (≥1).
- `STABLE_CYCLES`, 1024: consecutive locked clk cycles required before release (≥1).

Ports:
- `clk`, in, 1: 50 MHz reference clock. Same net as the PLL `refclk`.
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: PLL lock indicator. Asynchronous to `clk`.
- `soft_reset_req`, in, 1: single-cycle request to restart the full sequence.
- `pll_rst`, out, 1: reset to the PLL.
- `sys_rst`, out, 1: system reset. Active high. Consumers re-synchronize it into the `outclk_0` domain.
- `ready`, out, 1: the sequence is complete and the PLL is locked.
- `lock_lost`, out, 1: sticky flag, set when lock drops while in RUN.
- `retry_count`, out, 8: saturating count of lock-timeout retries.

## Operation
- **Synchronizer.** `pll_locked` passes through `SYNC_STAGES` flops to give `locked_s`. Reset clears all stages to 0.
- **State machine.** One-hot states PLL_RST, WAIT_LOCK, STABLE, RUN. A single shared counter `cnt` is cleared on every state change.
- **PLL_RST.**
  - Outputs: `pll_rst`=1, `sys_rst`=1.
  - When `cnt`==`PLL_RST_CYCLES`-1, go to WAIT_LOCK.
  - `locked_s` is ignored in this state.
- **WAIT_LOCK.**
  - Outputs: `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when `cnt`==`LOCK_TIMEOUT`-1, go to PLL_RST and increment `retry_count`. It saturates at 255.
- **STABLE.**
  - Outputs: `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=0, go to WAIT_LOCK. The timeout restarts.
  - Otherwise, when `cnt`==`STABLE_CYCLES`-1, go to RUN.
- **RUN.**
  - Outputs: `pll_rst`=0, `sys_rst`=0, `ready`=1.
  - If `locked_s`=0, go to WAIT_LOCK and set `lock_lost`.
- **Soft reset.** `soft_reset_req`=1 in any state forces PLL_RST next cycle and clears `lock_lost`. `retry_count` is kept.
- **Priority.** `rst` > `soft_reset_req` > lock loss/acquire > counter expiry.
- **Counter width.** `cnt` is $clog2 of the maximum of the three cycle parameters. It never wraps: it is compared for equality and cleared on transition.
- **`lock_lost`.** Cleared only by `rst` or `soft_reset_req`.

## Timing
- **Reset values.** While `rst` is high: state=PLL_RST, `cnt`=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `lock_lost`=0, `retry_count`=0, synchronizer=0.
- **Registered outputs.**
  - All outputs are registered.
  - Each output is decoded from next-state and updates on the same edge the state changes.
  - Outputs have no combinational path from inputs.
- **`pll_rst` pulse.** After `rst` deasserts, `pll_rst` stays high for exactly `PLL_RST_CYCLES` cycles. Every retry produces the same pulse width.
- **Lock detect latency.** A rising `pll_locked` reaches WAIT_LOCK→STABLE decoding after `SYNC_STAGES` edges. STABLE is entered on the following edge.
- **Release latency.** `sys_rst` falls and `ready` rises `STABLE_CYCLES` cycles after STABLE entry, provided `locked_s` remains 1.
- **Re-assert latency.** Loss of lock re-asserts `sys_rst` `SYNC_STAGES`+1 cycles after `pll_locked` falls.
- **Glitches.** A `locked_s` glitch of 1 cycle in STABLE restarts qualification from WAIT_LOCK.
- **Soft reset during PLL_RST.** Restarts the pulse from `cnt`=0.

## Structure
- Shared package `pll_seq_pkg`: the state enum, one-hot, 4 bits.
- Counter-width helper function in the same package.
- Sub-module `sync_ff`: a parameterized N-stage bit synchronizer. It is reusable for the `sys_rst` crossing into the 8 MHz domain.
- The FSM and counter live in this module.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8.

1. **Clean bring-up.** Release `rst`, then raise `pll_locked` 10 cycles later. Required: `pll_rst` is high for 4 cycles; `sys_rst` falls and `ready` rises 8 cycles after STABLE entry; `retry_count`=0.
2. **Timeout retry.** Keep `pll_locked`=0 for 60 cycles. Required: `pll_rst` pulses recur every 24 cycles (4+20); `retry_count` increments per timeout. Then force 300 timeouts: `retry_count` saturates at 255.
3. **Glitchy lock.** Lock, drop for 1 cycle at STABLE `cnt`=5, then hold. Required: STABLE is re-entered; release happens 8 cycles after the second entry, not the first.
4. **Loss in RUN.** Drop `pll_locked` after `ready`. Required: `sys_rst`=1, `ready`=0 and `lock_lost`=1, 3 cycles after the drop. Relock: release after 8 stable cycles with `lock_lost` still 1.
5. **Soft reset.** Pulse `soft_reset_req` in RUN, and simultaneously with a lock drop. Required: PLL_RST is entered next cycle; `lock_lost`=0; the 4-cycle `pll_rst` pulse restarts.
6. **Reset mid-sequence.** Assert `rst` in STABLE. Required: all outputs return to reset values on the next edge; the synchronizer is cleared.
